// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the IF-stage program counter
package pc_pkg;

   // Fetch FSM states
   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_STALLED = 2'd2
   } pc_state_e;

   localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
   localparam int          PC_INC          = 4;

   // Low PC bits that must be zero for a legal 32-bit instruction address
   localparam logic [1:0]  IALIGN_MASK     = 2'b11;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory fetch request handshake
interface pc_fetch_unit_if #(
   parameter int XLEN = 32
) ();

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready
   );

endinterface

// File: rtl/pc_redirect_buffer.sv
// rtl/pc_redirect_buffer.sv - holds a redirect/trap that arrived while a fetch was outstanding
module pc_redirect_buffer
   import pc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            clr_i,
   input  logic            capture_i,
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] trap_target_i,
   input  logic            redir_valid_i,
   input  logic [XLEN-1:0] redir_target_i,
   output logic            pend_valid_o,
   output logic [XLEN-1:0] pend_target_o,
   output logic            pend_misalign_o
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] target_q, target_d;
   logic            is_trap_q, is_trap_d;
   logic            misalign_q, misalign_d;

   // A trap always wins; a redirect may only replace an empty entry or an older redirect
   always_comb begin
      valid_d    = valid_q;
      target_d   = target_q;
      is_trap_d  = is_trap_q;
      misalign_d = misalign_q;
      if (clr_i) begin
         valid_d    = 1'b0;
         is_trap_d  = 1'b0;
         misalign_d = 1'b0;
      end else if (capture_i) begin
         if (trap_valid_i) begin
            valid_d    = 1'b1;
            is_trap_d  = 1'b1;
            target_d   = {trap_target_i[XLEN-1:2], trap_target_i[1:0] & ~IALIGN_MASK};
            misalign_d = |(trap_target_i[1:0] & IALIGN_MASK);
         end else if (redir_valid_i && !(valid_q && is_trap_q)) begin
            valid_d    = 1'b1;
            is_trap_d  = 1'b0;
            target_d   = {redir_target_i[XLEN-1:2], redir_target_i[1:0] & ~IALIGN_MASK};
            misalign_d = |(redir_target_i[1:0] & IALIGN_MASK);
         end
      end
   end

   // Pending entry storage; reset discards whatever was buffered
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q    <= 1'b0;
         target_q   <= '0;
         is_trap_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         target_q   <= target_d;
         is_trap_q  <= is_trap_d;
         misalign_q <= misalign_d;
      end
   end

   assign pend_valid_o    = valid_q;
   assign pend_target_o   = target_q;
   assign pend_misalign_o = misalign_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - IF-stage program counter and fetch-request generator
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
   parameter int              INC          = PC_INC
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall_i,
   input  logic            redir_valid_i,
   input  logic [XLEN-1:0] redir_target_i,
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] trap_target_i,
   pc_fetch_unit_if.master imem,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus_inc_o,
   output logic            kill_o,
   output logic            misalign_o
);

   localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            req_q, req_d;
   logic            misalign_q, misalign_d;

   logic            accept;
   logic            evt_valid;
   logic [XLEN-1:0] evt_raw;
   logic [XLEN-1:0] evt_target;
   logic            evt_misalign;
   logic [XLEN-1:0] next_pc;
   logic            next_misalign;
   logic            buf_clr;
   logic            buf_capture;
   logic            pend_valid;
   logic [XLEN-1:0] pend_target;
   logic            pend_misalign;

   assign accept       = req_q & imem.imem_ready;
   assign evt_valid    = trap_valid_i | redir_valid_i;
   assign evt_raw      = trap_valid_i ? trap_target_i : redir_target_i;
   assign evt_target   = {evt_raw[XLEN-1:2], evt_raw[1:0] & ~IALIGN_MASK};
   assign evt_misalign = evt_valid & (|(evt_raw[1:0] & IALIGN_MASK));

   // Only an un-accepted FETCH cycle can park a redirect; the accept itself consumes it
   assign buf_capture  = (state_q == ST_FETCH) & ~accept;
   assign buf_clr      = accept;

   pc_redirect_buffer #(
      .XLEN (XLEN)
   ) u_redirect_buffer (
      .clk             (clk),
      .reset_n         (reset_n),
      .clr_i           (buf_clr),
      .capture_i       (buf_capture),
      .trap_valid_i    (trap_valid_i),
      .trap_target_i   (trap_target_i),
      .redir_valid_i   (redir_valid_i),
      .redir_target_i  (redir_target_i),
      .pend_valid_o    (pend_valid),
      .pend_target_o   (pend_target),
      .pend_misalign_o (pend_misalign)
   );

   // Next fetch address on accept: trap > redirect > pending > sequential
   always_comb begin
      next_pc       = pc_q + INC_W;
      next_misalign = 1'b0;
      if (evt_valid) begin
         next_pc       = evt_target;
         next_misalign = evt_misalign;
      end else if (pend_valid) begin
         next_pc       = pend_target;
         next_misalign = pend_misalign;
      end
   end

   // FSM next-state: direct PC load when idle, handshake-gated update when fetching
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = 1'b0;
      case (state_q)
         ST_BOOT, ST_STALLED: begin
            if (evt_valid) begin
               pc_d       = evt_target;
               misalign_d = evt_misalign;
            end
            state_d = stall_i ? ST_STALLED : ST_FETCH;
         end
         ST_FETCH: begin
            if (accept) begin
               pc_d       = next_pc;
               misalign_d = next_misalign;
               state_d    = stall_i ? ST_STALLED : ST_FETCH;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
      req_d = (state_d == ST_FETCH);
   end

   // FSM state and registered outputs; reset withdraws any outstanding request
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         req_q      <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_q      <= req_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign pc_o           = pc_q;
   assign pc_plus_inc_o  = pc_q + INC_W;
   assign misalign_o     = misalign_q;
   assign kill_o         = accept & (pend_valid | evt_valid);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed table-driven bench for pc_fetch_unit
module tb_pc_fetch_unit;

   logic        clk;
   logic        reset_n;
   logic        stall_i;
   logic        redir_valid_i;
   logic [31:0] redir_target_i;
   logic        trap_valid_i;
   logic [31:0] trap_target_i;
   logic [31:0] pc_o;
   logic [31:0] pc_plus_inc_o;
   logic        kill_o;
   logic        misalign_o;

   int n_pass;
   int n_total;

   pc_fetch_unit_if #(.XLEN(32)) imem_if ();

   pc_fetch_unit #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0000_0000),
      .INC          (4)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .stall_i        (stall_i),
      .redir_valid_i  (redir_valid_i),
      .redir_target_i (redir_target_i),
      .trap_valid_i   (trap_valid_i),
      .trap_target_i  (trap_target_i),
      .imem           (imem_if),
      .pc_o           (pc_o),
      .pc_plus_inc_o  (pc_plus_inc_o),
      .kill_o         (kill_o),
      .misalign_o     (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic        ready;
      logic        rv;
      logic [31:0] rt;
      logic        tv;
      logic [31:0] tt;
      logic        e_req;
      logic [31:0] e_pc;
      logic        e_kill;
      logic        e_mis;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(logic rst_n, logic stall, logic ready,
                              logic rv, logic [31:0] rt, logic tv, logic [31:0] tt,
                              logic e_req, logic [31:0] e_pc, logic e_kill, logic e_mis);
      vec_t r;
      r.rst_n = rst_n; r.stall = stall; r.ready = ready;
      r.rv = rv; r.rt = rt; r.tv = tv; r.tt = tt;
      r.e_req = e_req; r.e_pc = e_pc; r.e_kill = e_kill; r.e_mis = e_mis;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Apply one cycle of inputs just after the falling edge, then let them settle
   task automatic step(input logic rst_n, input logic stall, input logic ready,
                       input logic rv, input logic [31:0] rt,
                       input logic tv, input logic [31:0] tt);
      @(negedge clk);
      reset_n        = rst_n;
      stall_i        = stall;
      imem_if.imem_ready = ready;
      redir_valid_i  = rv;
      redir_target_i = rt;
      trap_valid_i   = tv;
      trap_target_i  = tt;
      #1;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      reset_n = 1'b0; stall_i = 1'b0; imem_if.imem_ready = 1'b0;
      redir_valid_i = 1'b0; redir_target_i = '0;
      trap_valid_i = 1'b0; trap_target_i = '0;
      repeat (2) @(posedge clk);

      //            rst stl rdy rv  rt            tv  tt            req pc            kill mis
      // sequential fetch after reset
      tbl.push_back(v(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_000C, 0, 0));
      // reset while a request is outstanding
      tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0010, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 0, 0));
      // redirect while imem not ready: address holds, kill on accept
      tbl.push_back(v(1, 0, 0, 1, 32'h100,      0, 32'h0,        1, 32'h0000_0008, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 1, 0));
      // pending redirect replaced by a later trap
      tbl.push_back(v(1, 0, 0, 1, 32'h200,      0, 32'h0,        1, 32'h0000_0100, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 32'h0,        1, 32'h80,       1, 32'h0000_0100, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0100, 1, 0));
      // pending trap survives a later redirect
      tbl.push_back(v(1, 0, 0, 0, 32'h0,        1, 32'h80,       1, 32'h0000_0080, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 32'h300,      0, 32'h0,        1, 32'h0000_0080, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0080, 1, 0));
      // stalled accept, then misaligned redirect while stalled
      tbl.push_back(v(1, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0080, 0, 0));
      tbl.push_back(v(1, 1, 1, 1, 32'h103,      0, 32'h0,        0, 32'h0000_0084, 0, 0));
      tbl.push_back(v(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0100, 0, 1));
      tbl.push_back(v(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0100, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0100, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst_n, tbl[i].stall, tbl[i].ready, tbl[i].rv, tbl[i].rt, tbl[i].tv, tbl[i].tt);
         chk($sformatf("v%0d.req", i),   {31'b0, imem_if.imem_req}, {31'b0, tbl[i].e_req});
         chk($sformatf("v%0d.pc", i),    pc_o,                      tbl[i].e_pc);
         chk($sformatf("v%0d.addr", i),  imem_if.imem_addr,         tbl[i].e_pc);
         chk($sformatf("v%0d.pcinc", i), pc_plus_inc_o,             tbl[i].e_pc + 32'd4);
         chk($sformatf("v%0d.kill", i),  {31'b0, kill_o},           {31'b0, tbl[i].e_kill});
         chk($sformatf("v%0d.mis", i),   {31'b0, misalign_o},       {31'b0, tbl[i].e_mis});
      end

      // stall during accept of 0x10, and stall never withdraws an open request
      step(0, 0, 0, 0, 32'h0, 0, 32'h0);
      step(1, 0, 1, 0, 32'h0, 0, 32'h0);
      chk("s.boot_req", {31'b0, imem_if.imem_req}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 1, 0, 32'h0, 0, 32'h0);
         chk($sformatf("s.seq%0d", k), pc_o, 32'(k * 4));
      end
      step(1, 1, 1, 0, 32'h0, 0, 32'h0);
      chk("s.pc10", pc_o, 32'h10);
      chk("s.req10", {31'b0, imem_if.imem_req}, 32'd1);
      step(1, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("s.stall_req", {31'b0, imem_if.imem_req}, 32'd0);
      chk("s.stall_pc", pc_o, 32'h14);
      step(1, 1, 0, 0, 32'h0, 0, 32'h0);
      chk("s.resume_req", {31'b0, imem_if.imem_req}, 32'd1);
      chk("s.resume_pc", pc_o, 32'h14);
      step(1, 0, 1, 0, 32'h0, 0, 32'h0);
      chk("s.hold_req", {31'b0, imem_if.imem_req}, 32'd1);
      chk("s.hold_addr", imem_if.imem_addr, 32'h14);

      // redirect arriving in an accept cycle, then PC wrap-around
      step(1, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0);
      chk("w.pc18", pc_o, 32'h18);
      chk("w.kill_live", {31'b0, kill_o}, 32'd1);
      step(1, 0, 1, 0, 32'h0, 0, 32'h0);
      chk("w.pc_top", pc_o, 32'hFFFF_FFFC);
      chk("w.pcinc_wrap", pc_plus_inc_o, 32'h0);
      chk("w.kill_clear", {31'b0, kill_o}, 32'd0);
      step(1, 0, 1, 0, 32'h0, 0, 32'h0);
      chk("w.pc_wrap", pc_o, 32'h0);
      chk("w.req_wrap", {31'b0, imem_if.imem_req}, 32'd1);
      step(0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("w.pc4", pc_o, 32'h4);
      step(1, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("w.rst_req", {31'b0, imem_if.imem_req}, 32'd0);
      chk("w.rst_pc", pc_o, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
